// File: rtl/fft_frame_pkg.sv
// Shared types and helpers for the FFT framing stage.
// State enum, frame-length clamp and point-count encoding.
package fft_frame_pkg;

  localparam int LEN_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(
    input logic [LEN_W-1:0] v,
    input int               lo,
    input int               hi
  );
    int x;
    x = int'(v);
    if (x < lo) return LEN_W'(lo);
    if (x > hi) return LEN_W'(hi);
    return v;
  endfunction

  function automatic logic [15:0] pts_of(
    input logic [LEN_W-1:0] len
  );
    return 16'(1) << len;
  endfunction

endpackage

// File: rtl/st_skid_buf.sv
// Two-entry valid/ready skid buffer with registered in_ready.
// Ports: in_* upstream beat, out_* downstream beat, RST_DATA = reset payload.
module st_skid_buf #(
  parameter int           W        = 8,
  parameter logic [W-1:0] RST_DATA = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_v_q, main_v_d;
  logic         skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         pop;

  assign in_ready_o  = !skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;
  assign pop         = main_v_q && out_ready_i;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (pop) main_v_d = 1'b0;
    if (skid_v_q) begin
      // skid drains into main before anything new is taken
      if (pop) begin
        main_v_d = 1'b1;
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end
    end else if (in_valid_i) begin
      if (!main_v_q || pop) begin
        main_v_d = 1'b1;
        main_d   = in_data_i;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = in_data_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= RST_DATA;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frames an ADC sample stream into sop/eop-tagged FFT sink beats.
// Ports: in_* sample stream, sink_* FFT core sink, cfg_* frame setup, status counters.
module fft_frame_ctrl
  import fft_frame_pkg::*;
#(
  parameter int DATA_W    = 14,
  parameter int MAX_LOG2  = 10,
  parameter int MIN_LOG2  = 3,
  parameter bit REAL_ONLY = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [LEN_W-1:0]    cfg_len_log2,
  input  logic                cfg_inverse,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  output logic                sink_valid,
  input  logic                sink_ready,
  output logic                sink_sop,
  output logic                sink_eop,
  output logic [DATA_W-1:0]   sink_real,
  output logic [DATA_W-1:0]   sink_imag,
  output logic [1:0]          sink_error,
  output logic                inverse,
  output logic [MAX_LOG2:0]   fft_pts,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         stall_cnt
);

  localparam int IW    = MAX_LOG2;
  localparam int PTS_W = MAX_LOG2 + 1;
  localparam int PW    = 3 + LEN_W + 2 * DATA_W;
  localparam logic [PW-1:0] RST_PL =
    {3'b000, LEN_W'(MAX_LOG2), {(2 * DATA_W){1'b0}}};

  state_e            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, last_idx;
  logic [LEN_W-1:0]  len_q, len_d, cur_len, out_len;
  logic              inv_q, inv_d, cur_inv;
  logic              gate_q, gate_d;
  logic              skid_rdy, accept, first, last;
  logic [15:0]       frame_q, frame_d, stall_q, stall_d;
  logic [DATA_W-1:0] imag_in;
  logic [PW-1:0]     pl_in, pl_out;

  assign in_ready = gate_q && skid_rdy;
  assign accept   = in_valid && in_ready;

  // idx == 0 marks a frame boundary: config is sampled on that beat
  assign first    = (idx_q == '0);
  assign cur_len  = first ? clamp_len(cfg_len_log2, MIN_LOG2, MAX_LOG2) : len_q;
  assign cur_inv  = first ? cfg_inverse : inv_q;
  assign last_idx = ~({IW{1'b1}} << cur_len);
  assign last     = (idx_q == last_idx);
  assign imag_in  = REAL_ONLY ? '0 : in_imag;
  assign pl_in    = {first, last, cur_inv, cur_len, in_real, imag_in};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    inv_d   = inv_q;
    if (accept) begin
      len_d = cur_len;
      inv_d = cur_inv;
      if (last) begin
        idx_d   = '0;
        state_d = enable ? RUN : IDLE;
      end else begin
        idx_d   = idx_q + IW'(1);
        state_d = RUN;
      end
    end else if (state_q == RUN && first && !enable) begin
      state_d = IDLE;
    end
    // an open frame always runs to completion regardless of enable
    gate_d = enable || (state_d == RUN && idx_d != '0);
  end

  always_comb begin
    frame_d = frame_q;
    stall_d = stall_q;
    if (sink_valid && sink_ready && sink_eop) frame_d = frame_q + 16'd1;
    if (state_q == RUN && !first && !in_valid && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= LEN_W'(MAX_LOG2);
      inv_q   <= 1'b0;
      gate_q  <= 1'b0;
      frame_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      inv_q   <= inv_d;
      gate_q  <= gate_d;
      frame_q <= frame_d;
      stall_q <= stall_d;
    end
  end

  st_skid_buf #(
    .W        (PW),
    .RST_DATA (RST_PL)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (accept),
    .in_ready_o  (skid_rdy),
    .in_data_i   (pl_in),
    .out_valid_o (sink_valid),
    .out_ready_i (sink_ready),
    .out_data_o  (pl_out)
  );

  assign {sink_sop, sink_eop, inverse, out_len, sink_real, sink_imag} = pl_out;
  assign fft_pts    = PTS_W'(pts_of(out_len));
  assign sink_error = 2'b00;
  assign frame_cnt  = frame_q;
  assign stall_cnt  = stall_q;

endmodule
